// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: byte-level 4-wire SPI transmitter for the ST7735 LCD.
//   Takes a 9-bit word (bit 8 = D/C, bits 7:0 = payload), shifts the payload
//   MSB-first in SPI mode 0 with CS/DC framing, pulses wr_done once per byte,
//   then holds off new requests for GAP_CYCLES so upstream can update data.
//
// Parameters:
//   CLK_DIV    SCL half-period in sys_clk cycles (1..15)
//   GAP_CYCLES idle cycles after wr_done during which en_write is ignored (>=3)
//
// Ports:
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   data      in   [8] D/C (0 cmd, 1 data), [7:0] byte
//   en_write  in   level request, sampled only in IDLE
//   wr_done   out  one-cycle pulse when a byte has fully shifted out
//   busy      out  high in every state except IDLE
//   lcd_scl   out  SPI clock (idles low)
//   lcd_sda   out  SPI MOSI
//   lcd_dc    out  data/command select
//   lcd_cs    out  chip select, active low
//
// Optional build macro:
//   LCD_SPI_CS_HOLD_EN  keep lcd_cs low across DONE/GAP; release it only once
//                       IDLE sees en_write low, so a byte stream shares one
//                       CS frame. Undefined: CS rises in DONE after every byte.

module lcd_spi_writer #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_scl,
  output logic       lcd_sda,
  output logic       lcd_dc,
  output logic       lcd_cs
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state, state_n;
  logic [3:0]    ph_cnt, ph_cnt_n;     // cycles within the current SCL half
  logic          hi, hi_n;             // 0: SCL-low half, 1: SCL-high half
  logic [2:0]    bit_cnt, bit_cnt_n;   // 7 down to 0
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          dc_n, cs_n;

  // SDA is the shift register MSB. No shift after bit 0, so SDA keeps
  // showing bit 0 until the next latch.
  assign lcd_sda = shreg[7];

  always_comb begin
    state_n   = state;
    ph_cnt_n  = ph_cnt;
    hi_n      = hi;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    shreg_n   = shreg;
    dc_n      = lcd_dc;
    case (state)
      IDLE: begin
        if (en_write) begin
          state_n   = SHIFT;
          ph_cnt_n  = '0;
          hi_n      = 1'b0;
          bit_cnt_n = 3'd7;
          shreg_n   = data[7:0];
          dc_n      = data[8];
        end
      end
      SHIFT: begin
        if (ph_cnt == 4'(CLK_DIV - 1)) begin
          ph_cnt_n = '0;
          hi_n     = ~hi;
          // End of a high half closes the bit; the shift lands on the
          // falling edge so SDA only moves while SCL is low.
          if (hi) begin
            if (bit_cnt == 3'd0) begin
              state_n = DONE;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
              shreg_n   = {shreg[6:0], 1'b0};
            end
          end
        end else begin
          ph_cnt_n = ph_cnt + 4'd1;
        end
      end
      DONE: begin
        state_n   = GAP;
        gap_cnt_n = '0;
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = IDLE;
        else                                gap_cnt_n = gap_cnt + GW'(1);
      end
      default: state_n = IDLE;
    endcase

`ifdef LCD_SPI_CS_HOLD_EN
    cs_n = lcd_cs;
    if (state == IDLE && !en_write)     cs_n = 1'b1;
    else if (state == IDLE && en_write) cs_n = 1'b0;
`else
    cs_n = (state_n != SHIFT);
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= IDLE;
      ph_cnt  <= '0;
      hi      <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      lcd_dc  <= 1'b0;
      lcd_cs  <= 1'b1;
      lcd_scl <= 1'b0;
      wr_done <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      ph_cnt  <= ph_cnt_n;
      hi      <= hi_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      shreg   <= shreg_n;
      lcd_dc  <= dc_n;
      lcd_cs  <= cs_n;
      // Outputs are registered from next-state so they change cleanly on
      // the same edge as the state they belong to.
      lcd_scl <= (state_n == SHIFT) && hi_n;
      wr_done <= (state_n == DONE);
      busy    <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Self-checking bench for lcd_spi_writer. A timing model computes, for every
// cycle, what SCL/SDA/CS/DC/busy/wr_done must be from the sampling cycle L of
// the current byte; a bit capture on rising SCL rebuilds each byte.

module tb_lcd_spi_writer;
  localparam int D = 2;
  localparam int G = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [8:0] data = '0;
  logic       en_write = 1'b0;
  logic       wr_done, busy, lcd_scl, lcd_sda, lcd_dc, lcd_cs;

  lcd_spi_writer #(.CLK_DIV(D), .GAP_CYCLES(G)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .data    (data),
    .en_write(en_write),
    .wr_done (wr_done),
    .busy    (busy),
    .lcd_scl (lcd_scl),
    .lcd_sda (lcd_sda),
    .lcd_dc  (lcd_dc),
    .lcd_cs  (lcd_cs)
  );

  always #5 sys_clk = ~sys_clk;

  int         errors = 0, checks = 0;
  int         cyc = 0, L = -1000, next_idle = 0;
  logic [8:0] w = '0;
  logic       exp_cs_h = 1'b1;
  logic       prev_scl = 1'b0;
  logic [7:0] cap = '0;
  int         edges = 0, dut_dones = 0;
  bit         m_done_now = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_scl"},  lcd_scl, 0);
    chk({tag, "_sda"},  lcd_sda, 0);
    chk({tag, "_dc"},   lcd_dc,  0);
    chk({tag, "_cs"},   lcd_cs,  1);
    chk({tag, "_done"}, wr_done, 0);
    chk({tag, "_busy"}, busy,    0);
  endtask

  task automatic check_cycle();
    int   k;
    bit   in_sh;
    logic e_scl, e_sda, e_cs;
    in_sh = (cyc >= L + 1) && (cyc <= L + 16*D);
    k     = cyc - L - 1;
    e_scl = in_sh && ((k / D) % 2 == 1);
    e_sda = in_sh ? w[7 - k/(2*D)] : w[0];
`ifdef LCD_SPI_CS_HOLD_EN
    e_cs = exp_cs_h;
`else
    e_cs = !in_sh;
`endif
    chk("scl",     lcd_scl, e_scl);
    chk("sda",     lcd_sda, e_sda);
    chk("cs",      lcd_cs,  e_cs);
    chk("dc",      lcd_dc,  w[8]);
    chk("busy",    busy,    (cyc >= L + 1) && (cyc <= L + 16*D + 1 + G));
    chk("wr_done", wr_done, cyc == L + 16*D + 1);
    if (!prev_scl && lcd_scl === 1'b1) begin
      cap = {cap[6:0], lcd_sda};
      edges++;
    end
    prev_scl = lcd_scl;
    if (wr_done === 1'b1) dut_dones++;
    m_done_now = (cyc == L + 16*D + 1);
    if (m_done_now) begin
      chk("byte",  cap,   w[7:0]);
      chk("edges", edges, 8);
      cap   = '0;
      edges = 0;
    end
  endtask

  // Advance one clock: decide (from the model) whether this cycle samples a
  // request, then check the outputs of the following cycle.
  task automatic tick();
    logic cs_nx;
    cs_nx = exp_cs_h;
    if (cyc >= next_idle) begin
      if (en_write) begin
        L         = cyc;
        w         = data;
        next_idle = cyc + 16*D + G + 2;
        cs_nx     = 1'b0;
      end else begin
        cs_nx = 1'b1;
      end
    end
    @(posedge sys_clk);
    #1;
    cyc++;
    exp_cs_h = cs_nx;
    check_cycle();
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_done_now && n < 400);
    chk({tag, "_done_seen"}, m_done_now, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    en_write = 1'b0;
    while (cyc < next_idle && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic send(input logic [8:0] wd);
    wait_idle();
    data     = wd;
    en_write = 1'b1;
    tick();
    en_write = 1'b0;
    wait_done("send");
  endtask

  logic [8:0] bw[11];
  int         d0;

  initial begin
    // Reset state
    repeat (3) @(posedge sys_clk);
    #1;
    check_reset_outputs("reset");
    sys_rst = 1'b0;

    // en_write low at the sampling cycle: nothing happens
    repeat (3) tick();

    // Command byte 0x2A
    send(9'h02A);
    chk("t1_dc", lcd_dc, 0);
    chk("t1_pulse", wr_done, 1);
    tick();
    chk("t1_pulse_one_cycle", wr_done, 0);

    // Data byte 0xF8
    send(9'h1F8);
    chk("t2_dc", lcd_dc, 1);

    // Requests and data churn during SHIFT/GAP are ignored
    d0 = dut_dones;
    wait_idle();
    data     = 9'h155;
    en_write = 1'b1;
    tick();
    while (cyc < next_idle) begin
      en_write = 1'($urandom_range(0, 1));
      data     = 9'($urandom);
      tick();
    end
    en_write = 1'b0;
    repeat (4) tick();
    chk("ignore_count", dut_dones - d0, 1);

    // Sustained traffic: en_write held, data updated 3 cycles after wr_done
    bw[0] = 9'h02A;
    bw[1] = 9'h100;
    for (int i = 2; i < 11; i++) bw[i] = 9'($urandom);
    d0 = dut_dones;
    wait_idle();
    data     = bw[0];
    en_write = 1'b1;
    for (int i = 0; i < 11; i++) begin
      wait_done("burst");
      repeat (3) tick();
      if (i < 10) data = bw[i + 1];
      else        en_write = 1'b0;
    end
    repeat (4) tick();
    chk("burst_count", dut_dones - d0, 11);

    // Reset in the middle of bit 4 aborts the byte
    wait_idle();
    data     = 9'h1A5;
    en_write = 1'b1;
    tick();
    en_write = 1'b0;
    while (cyc < L + 1 + 7*D) tick();
    sys_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    d0 = dut_dones;
    repeat (2) @(posedge sys_clk);
    #1;
    cyc += 2;
    chk("midrst_no_done", wr_done, 0);
    L         = -1000;
    w         = '0;
    exp_cs_h  = 1'b1;
    cap       = '0;
    edges     = 0;
    prev_scl  = 1'b0;
    next_idle = cyc;
    sys_rst   = 1'b0;
    repeat (2) tick();
    chk("midrst_no_done_after", dut_dones - d0, 0);
    send(9'h0FF);

    // Random words with random idle spacing
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 4)) tick();
      send(9'($urandom));
    end
    repeat (G + 3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_spi_writer.md
Name: lcd_spi_writer

Overview:
- Byte-level 4-wire SPI transmitter for the ST7735 LCD. It sits directly downstream of the character/command generators, such as the show-char stage.
- Accepts a 9-bit word: bit 8 is D/C, bits 7:0 are the payload. Shifts the payload MSB-first on SCL/SDA with CS and DC framing.
- Returns a one-cycle wr_done pulse per byte. Upstream stages register wr_done and advance their counters on it.

Parameters:
- CLK_DIV, 2: SCL half-period in sys_clk cycles; legal range 1..15.
- GAP_CYCLES, 3: idle cycles after wr_done during which en_write is ignored, so upstream can update data. Must be ≥3.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- data  in  9  [8]=D/C (0 command, 1 data), [7:0] byte to send.
- en_write  in  1  level request; sampled only in IDLE.
- wr_done  out  1  one-cycle pulse when a byte has fully shifted out.
- busy  out  1  high in every state except IDLE.
- lcd_scl  out  1  SPI clock, mode 0 (idles low, LCD samples on rising edge).
- lcd_sda  out  1  SPI MOSI.
- lcd_dc  out  1  data/command select.
- lcd_cs  out  1  chip select, active low.

Behaviour:
- Reset values: lcd_scl=0, lcd_sda=0, lcd_dc=0, lcd_cs=1, wr_done=0, busy=0; FSM=IDLE, all counters 0.
- Reset mid-byte aborts the byte immediately: outputs go to reset values and no wr_done is issued.
- FSM states: IDLE, SHIFT, DONE, GAP.
- IDLE, en_write=1 in cycle L:
  - Latch data[7:0] into the shift register and data[8] into lcd_dc.
  - Registered outputs take effect in L+1: lcd_cs=0, lcd_sda=data[7], lcd_scl=0, busy=1.
  - Go to SHIFT.
- SHIFT:
  - Each bit is CLK_DIV cycles with SCL low, then CLK_DIV cycles with SCL high.
  - SDA changes only on the SCL-low phase start, i.e. coincident with the falling edge or the first bit's start.
  - A 3-bit bit counter counts 7 down to 0, with a CLK_DIV phase counter.
  - After bit 0's high phase, SCL returns low and the FSM goes to DONE.
- DONE (single cycle), in cycle L+16*CLK_DIV+1:
  - wr_done=1, lcd_cs=1, lcd_scl=0.
  - Go to GAP. With CLK_DIV=2, wr_done lands in L+33.
- GAP:
  - Stays GAP_CYCLES cycles; busy=1, en_write ignored.
  - Then IDLE. The earliest next sample is cycle (wr_done cycle)+GAP_CYCLES+1, i.e. t+4 for the default.
- Sustained traffic: en_write held high continuously yields back-to-back bytes, each with the data value present at its sampling cycle.
- Timing guarantee: upstream updates data within 3 cycles of wr_done, so the gap prevents the same word being re-sent.
- en_write low at the sampling cycle: no transaction, remain IDLE.
- en_write and data changes outside IDLE have no effect, and the latched word is not disturbed.
- lcd_dc holds its value until the next latch.
- lcd_sda after the last bit holds bit 0 until the next latch.
- Bit order is MSB first. Exactly 8 rising SCL edges occur per byte.

Optional Feature:
- Macro: LCD_SPI_CS_HOLD_EN.
- Defined: lcd_cs stays low through DONE and GAP. It deasserts only when the FSM is in IDLE for a cycle with en_write=0, so streams such as an 11-byte window set or pixel data share one CS frame.
- Undefined: lcd_cs rises in DONE after every byte. This is the default and the behaviour described above.

Test Plan:
- Reset, then data=9'h02A with en_write=1 at L, CLK_DIV=2 -> lcd_dc=0, CS low from L+1, SDA bits 0,0,1,0,1,0,1,0 sampled on 8 rising SCL, wr_done single pulse at L+33, CS high at L+33.
- data=9'h1F8 -> lcd_dc=1, bits 1,1,1,1,1,0,0,0; busy high L+1 through the end of GAP.
- en_write held high, with data switching 9'h02A->9'h100 three cycles after wr_done -> second byte starts at wr_done+4 and carries 0x00 with dc=1. No duplicate 0x2A and no missed byte across an 11-word burst: exactly 11 wr_done pulses.
- en_write pulsed high only during SHIFT or GAP -> ignored; the only wr_done count is from bytes sampled in IDLE.
- sys_rst asserted in the middle of bit 4 -> the same cycle shows scl=0, cs=1, sda=0, dc=0, busy=0; no wr_done; a fresh 9'h0FF after release transmits 8 ones correctly.
- With LCD_SPI_CS_HOLD_EN: 3 back-to-back bytes, then en_write=0 -> CS low continuously across all 3, high one cycle after IDLE sees en_write=0.
